// File: rtl/vga_fb_pkg.sv
// Shared constants and swap-state encoding for the VGA frame-buffer arbiter.
package vga_fb_pkg;

   localparam int unsigned FB_W        = 320;
   localparam int unsigned FB_H        = 240;
   localparam int unsigned SCALE_SHIFT = 1;
   localparam int unsigned ADDR_W      = 17;
   localparam int unsigned DATA_W      = 12;
   localparam int unsigned V_VISIBLE   = 480;
   localparam int unsigned FB_SIZE     = FB_W * FB_H;

   typedef enum logic {
      SW_IDLE = 1'b0,
      SW_PEND = 1'b1
   } sw_state_t;

endpackage

// File: rtl/vga_fb_addr_map.sv
// Screen pixel to frame-buffer address: (y>>S)*FB_W + (x>>S), purely combinational.
// The multiply by FB_W is a constant shift-add over the set bits of FB_W.
module vga_fb_addr_map
   import vga_fb_pkg::*;
(
   input  logic [9:0]        i_pixel_x,
   input  logic [9:0]        i_pixel_y,
   output logic [ADDR_W-1:0] o_addr
);

   localparam int unsigned AW1 = ADDR_W + 1;

   logic [9:0]     w_fx;
   logic [9:0]     w_fy;
   logic [AW1-1:0] w_row;
   logic [AW1-1:0] w_sum;
   logic           w_unused_msb;

   assign w_fx = i_pixel_x >> SCALE_SHIFT;
   assign w_fy = i_pixel_y >> SCALE_SHIFT;

   // Row base = fb_y * FB_W as a sum of shifted copies of fb_y
   always_comb begin
      w_row = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (FB_W[i]) begin
            w_row = w_row + (AW1'(w_fy) << i);
         end
      end
   end

   assign w_sum        = w_row + AW1'(w_fx);
   assign o_addr       = w_sum[ADDR_W-1:0];
   // Visible pixels always map inside the buffer, so the carry bit is never set.
   assign w_unused_msb = w_sum[ADDR_W];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer SRAM arbiter: display fetch has priority, the game-logic
// writer takes every other slot. Returns fetched pixels 3 clk after the tick.
// Optional double buffering with a vblank-aligned swap: define FB_DOUBLE_BUFFER_EN.
module vga_fb_arbiter
   import vga_fb_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              p_tick,
   input  logic              visible,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              swap_req,
   output logic              swap_done,
   output logic              front_bank,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W:0]   sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic [DATA_W-1:0] rgb_out
);

   logic              w_disp;
   logic              w_blank;
   logic              w_wr_inrange;
   logic              w_wr_go;
   logic              w_front_bank;
   logic              w_wr_bank;
   logic [ADDR_W-1:0] w_rd_addr;

   logic              r_sram_en;
   logic              r_sram_we;
   logic [ADDR_W:0]   r_sram_addr;
   logic [DATA_W-1:0] r_sram_wdata;
   logic              r_rd_pend;
   logic              r_rd_pend2;
   logic              r_blank_pend;
   logic              r_blank_pend2;
   logic [DATA_W-1:0] r_rgb;

   vga_fb_addr_map u_addr_map (
      .i_pixel_x (pixel_x),
      .i_pixel_y (pixel_y),
      .o_addr    (w_rd_addr)
   );

   assign w_disp       = p_tick & visible;
   assign w_blank      = p_tick & ~visible;
   assign wr_ready     = ~w_disp;
   assign w_wr_inrange = ({1'b0, wr_addr} < (ADDR_W + 1)'(FB_SIZE));
   // Out-of-range writes still complete the handshake but never reach the SRAM.
   assign w_wr_go      = wr_valid & ~w_disp & w_wr_inrange;

`ifdef FB_DOUBLE_BUFFER_EN
   sw_state_t r_sw_state;
   logic      r_front_bank;
   logic      r_swap_done;
   logic      w_swap_pt;

   assign w_swap_pt    = p_tick & (pixel_x == 10'd0) & (pixel_y == 10'(V_VISIBLE));
   assign w_front_bank = r_front_bank;
   assign w_wr_bank    = ~r_front_bank;
   assign front_bank   = r_front_bank;
   assign swap_done    = r_swap_done;

   // Swap FSM: latch a request, flip banks at the first non-visible line start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sw_state   <= SW_IDLE;
         r_front_bank <= 1'b0;
         r_swap_done  <= 1'b0;
      end else begin
         r_swap_done <= 1'b0;
         case (r_sw_state)
            SW_IDLE: begin
               if (swap_req) begin
                  r_sw_state <= SW_PEND;
               end
            end
            SW_PEND: begin
               if (w_swap_pt) begin
                  r_sw_state   <= SW_IDLE;
                  r_front_bank <= ~r_front_bank;
                  r_swap_done  <= 1'b1;
               end
            end
            default: r_sw_state <= SW_IDLE;
         endcase
      end
   end
`else
   logic w_unused_swap;

   assign w_unused_swap = swap_req;
   assign w_front_bank  = 1'b0;
   assign w_wr_bank     = 1'b0;
   assign front_bank    = 1'b0;
   assign swap_done     = 1'b0;
`endif

   // Slot arbitration: register the winning SRAM command for issue next cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sram_en    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
      end else begin
         r_sram_en <= w_disp | w_wr_go;
         r_sram_we <= w_wr_go;
         if (w_disp) begin
            r_sram_addr <= {w_front_bank, w_rd_addr};
         end else if (w_wr_go) begin
            r_sram_addr  <= {w_wr_bank, wr_addr};
            r_sram_wdata <= wr_data;
         end
      end
   end

   // Return pipeline: tags follow the tick so rgb_out updates exactly at T+3
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend     <= 1'b0;
         r_rd_pend2    <= 1'b0;
         r_blank_pend  <= 1'b0;
         r_blank_pend2 <= 1'b0;
         r_rgb         <= '0;
      end else begin
         r_rd_pend     <= w_disp;
         r_rd_pend2    <= r_rd_pend;
         r_blank_pend  <= w_blank;
         r_blank_pend2 <= r_blank_pend;
         if (r_rd_pend2) begin
            r_rgb <= sram_rdata;
         end else if (r_blank_pend2) begin
            r_rgb <= '0;
         end
      end
   end

   assign sram_en    = r_sram_en;
   assign sram_we    = r_sram_we;
   assign sram_addr  = r_sram_addr;
   assign sram_wdata = r_sram_wdata;
   assign rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed table, hand sequences and a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_vga_fb_arbiter;

`ifdef FB_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        p_tick = 1'b0, visible = 1'b0;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [16:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic        swap_req = 1'b0;
   logic        swap_done, front_bank;
   logic        sram_en, sram_we;
   logic [17:0] sram_addr;
   logic [11:0] sram_wdata;
   logic [11:0] sram_rdata = '0;
   logic [11:0] rgb_out;

   always #5 clk = ~clk;

   vga_fb_arbiter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .p_tick     (p_tick),
      .visible    (visible),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .swap_req   (swap_req),
      .swap_done  (swap_done),
      .front_bank (front_bank),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .rgb_out    (rgb_out)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM contents as seen by the bench: a fixed pattern, one marked location.
   function automatic logic [11:0] mem_val(input logic [17:0] a);
      if (a == 18'h00281) return 12'hABC;
      return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h5A5;
   endfunction

   // Reference model state: expected command this cycle, display value, bank state.
   typedef struct {
      int          t;
      logic [11:0] v;
   } rgb_ev_t;
   rgb_ev_t     rq[$];
   bit          m_en, m_we, m_bank, m_done, m_pend;
   logic [17:0] m_addr;
   logic [11:0] m_wdata, m_rgb;
   int          cyc = 0;
   bit          s_ready, s_en, s_we, s_bank;
   logic [17:0] s_addr;
   logic [11:0] s_rgb;
   int          n_we = 0, n_rd = 0, n_done = 0;

   task automatic model_clear();
      m_en = 0; m_we = 0; m_bank = 0; m_done = 0; m_pend = 0;
      m_addr = '0; m_wdata = '0; m_rgb = '0;
      rq.delete();
   endtask

   task automatic idle_inputs();
      p_tick = 0; visible = 0; wr_valid = 0; swap_req = 0;
   endtask

   // One clock: compare at negedge, predict next cycle, then emulate the SRAM read port.
   task automatic step();
      rgb_ev_t     e;
      bit          rd_issued;
      logic [17:0] rd_a;
      logic [17:0] na;
      @(negedge clk);
      while (rq.size() > 0 && rq[0].t <= cyc) begin
         e = rq.pop_front();
         m_rgb = e.v;
      end
      s_ready = wr_ready; s_en = sram_en; s_we = sram_we; s_addr = sram_addr;
      s_rgb = rgb_out; s_bank = front_bank;
      chk("wr_ready", wr_ready, !(p_tick && visible));
      chk("sram_en", sram_en, m_en);
      chk("sram_we", sram_we, m_we);
      if (m_en) chk("sram_addr", sram_addr, m_addr);
      if (m_we) chk("sram_wdata", sram_wdata, m_wdata);
      chk("rgb_out", rgb_out, m_rgb);
      chk("front_bank", front_bank, m_bank);
      chk("swap_done", swap_done, m_done);
      n_we += int'(sram_we);
      n_rd += int'(sram_en && !sram_we);
      n_done += int'(swap_done);
      rd_issued = sram_en && !sram_we;
      rd_a = sram_addr;

      m_done = 0;
      if (p_tick && visible) begin
         na = {m_bank, 17'((int'(pixel_y) / 2) * 320 + int'(pixel_x) / 2)};
         m_en = 1; m_we = 0; m_addr = na;
         rq.push_back('{cyc + 3, mem_val(na)});
      end else if (wr_valid && int'(wr_addr) < 320 * 240) begin
         m_en = 1; m_we = 1; m_addr = {DB ? !m_bank : 1'b0, wr_addr}; m_wdata = wr_data;
      end else begin
         m_en = 0; m_we = 0;
      end
      if (p_tick && !visible) rq.push_back('{cyc + 3, 12'h000});
      if (DB) begin
         if (!m_pend) begin
            m_pend = swap_req;
         end else if (p_tick && pixel_x == 0 && pixel_y == 480) begin
            m_pend = 0; m_bank = !m_bank; m_done = 1;
         end
      end

      @(posedge clk);
      #1;
      sram_rdata = rd_issued ? mem_val(rd_a) : 12'($urandom);
      cyc++;
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      reset_n = 0;
      #1;
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_wdata", sram_wdata, 0);
      chk("rst_rgb_out", rgb_out, 0);
      chk("rst_swap_done", swap_done, 0);
      chk("rst_front_bank", front_bank, 0);
      model_clear();
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1;
      sram_rdata = '0;
   endtask

   typedef struct {
      bit tk, vis;
      int x, y;
      bit wv;
      int wa, wd;
      bit e_ready, e_en, e_we, e_wb;
      int e_addr;
   } vec_t;
   vec_t vt[12];

   initial begin
      int wa;
      int cnt;
      int we0, rd0, dn0;

      vt[0]  = '{1, 1,   2,   4, 1,      5, 'h111, 0, 1, 0, 0, 'h00281};
      vt[1]  = '{1, 1, 639, 479, 0,      0,     0, 0, 1, 0, 0,   76799};
      vt[2]  = '{1, 1,   0,   0, 0,      0,     0, 0, 1, 0, 0,       0};
      vt[3]  = '{0, 0,   0,   0, 1,    100, 'h123, 1, 1, 1, 1,     100};
      vt[4]  = '{0, 0,   0,   0, 1,  76800, 'h321, 1, 0, 0, 0,       0};
      vt[5]  = '{0, 0,   0,   0, 1,  76799, 'hFFF, 1, 1, 1, 1,   76799};
      vt[6]  = '{1, 0,  10,  10, 0,      0,     0, 1, 0, 0, 0,       0};
      vt[7]  = '{1, 0,  10,  10, 1,      7, 'h0A5, 1, 1, 1, 1,       7};
      vt[8]  = '{1, 1,   3,   1, 1,      9, 'h999, 0, 1, 0, 0,       1};
      vt[9]  = '{0, 0,   0,   0, 0,      0,     0, 1, 0, 0, 0,       0};
      vt[10] = '{0, 0,   0,   0, 1, 131071, 'h777, 1, 0, 0, 0,       0};
      vt[11] = '{1, 1,   1,   3, 0,      0,     0, 0, 1, 0, 0,     320};

      model_clear();
      idle_inputs();
      #1;
      do_reset();
      for (int i = 0; i < 3; i++) step();

      // Directed single-slot decisions
      for (int i = 0; i < 12; i++) begin
         p_tick = vt[i].tk; visible = vt[i].vis;
         pixel_x = 10'(vt[i].x); pixel_y = 10'(vt[i].y);
         wr_valid = vt[i].wv; wr_addr = 17'(vt[i].wa); wr_data = 12'(vt[i].wd);
         step();
         chk($sformatf("tbl%0d_ready", i), s_ready, vt[i].e_ready);
         idle_inputs();
         step();
         chk($sformatf("tbl%0d_en", i), s_en, vt[i].e_en);
         chk($sformatf("tbl%0d_we", i), s_we, vt[i].e_we);
         if (vt[i].e_en)
            chk($sformatf("tbl%0d_addr", i), s_addr, {DB && vt[i].e_wb, 17'(vt[i].e_addr)});
         step();
         step();
      end

      // Fetch latency: tick at T, pixel at T+3, held until the next tick
      p_tick = 1; visible = 1; pixel_x = 2; pixel_y = 4;
      step();
      idle_inputs();
      step();
      chk("t2_addr", s_addr, 18'h00281);
      step();
      chk("t2_hold_old", s_rgb !== 12'hABC, 1);
      step();
      chk("t2_rgb", s_rgb, 12'hABC);
      step();
      chk("t2_rgb_hold", s_rgb, 12'hABC);

      // Blanking tick: no access, black pixel at T+3
      p_tick = 1; visible = 0; pixel_x = 700; pixel_y = 10;
      step();
      idle_inputs();
      step();
      chk("t5_no_access", s_en, 0);
      step();
      chk("t5_rgb_before", s_rgb, 12'hABC);
      step();
      chk("t5_rgb_black", s_rgb, 0);

      // Writer held valid while the display takes one slot in four
      we0 = n_we; rd0 = n_rd;
      wa = 1000;
      for (int i = 0; i < 16; i++) begin
         p_tick = (i % 4 == 0); visible = 1; pixel_x = 10'(i); pixel_y = 10;
         wr_valid = 1; wr_addr = 17'(wa); wr_data = 12'(wa);
         step();
         if (s_ready) wa++;
      end
      idle_inputs();
      step();
      chk("t3_writes", n_we - we0, 12);
      chk("t3_reads", n_rd - rd0, 4);
      chk("t3_accepted", wa, 1012);
      for (int i = 0; i < 3; i++) step();

      // Reset while a read is on the SRAM bus
      p_tick = 1; visible = 1; pixel_x = 20; pixel_y = 20;
      step();
      do_reset();
      for (int i = 0; i < 4; i++) step();

      // Swap requested twice mid-frame; one flip at the vblank line start
      dn0 = n_done;
      pixel_x = 5; pixel_y = 100; swap_req = 1;
      step();
      swap_req = 0;
      step(); step();
      swap_req = 1;
      step();
      swap_req = 0;
      for (int i = 0; i < 4; i++) step();
      p_tick = 1; visible = 0; pixel_x = 0; pixel_y = 480;
      step();
      idle_inputs();
      step();
      chk("t6_bank", s_bank, DB);
      for (int i = 0; i < 4; i++) step();
      chk("t6_done_pulses", n_done - dn0, DB ? 1 : 0);
      p_tick = 1; visible = 1; pixel_x = 2; pixel_y = 4;
      step();
      idle_inputs();
      step();
      chk("t6_read_bank", s_addr, {DB, 17'h00281});
      wr_valid = 1; wr_addr = 5; wr_data = 12'h055;
      step();
      idle_inputs();
      step();
      chk("t6_write_bank", s_addr, 18'h00005);
      for (int i = 0; i < 3; i++) step();

      // Randomized traffic against the model
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (cnt == 0) begin
            p_tick = 1;
            cnt = $urandom_range(3, 5);
         end else begin
            p_tick = 0;
            cnt--;
         end
         visible = ($urandom % 5) != 0;
         pixel_x = 10'($urandom % 640);
         pixel_y = 10'($urandom % 480);
         if ($urandom % 40 == 0) begin
            visible = 0; pixel_x = 0; pixel_y = 480;
         end
         wr_valid = ($urandom % 3) != 0;
         wr_addr = ($urandom % 16 == 0) ? 17'(76800 + $urandom % 1000) : 17'($urandom % 76800);
         wr_data = 12'($urandom);
         swap_req = ($urandom % 30) == 0;
         step();
         if (i == 1500) begin
            do_reset();
            cnt = 0;
         end
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
